// File: rtl/vfu_wb_arbiter.sv
// rtl/vfu_wb_arbiter.sv - Round-robin arbiter merging ALU and MFPU result writes into one registered VRF write port.
module vfu_wb_arbiter #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 10,
  parameter int IdWidth   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alu_req_i,
  input  logic [IdWidth-1:0]     alu_id_i,
  input  logic [AddrWidth-1:0]   alu_addr_i,
  input  logic [DataWidth-1:0]   alu_wdata_i,
  input  logic [DataWidth/8-1:0] alu_be_i,
  output logic                   alu_gnt_o,
  input  logic                   mfpu_req_i,
  input  logic [IdWidth-1:0]     mfpu_id_i,
  input  logic [AddrWidth-1:0]   mfpu_addr_i,
  input  logic [DataWidth-1:0]   mfpu_wdata_i,
  input  logic [DataWidth/8-1:0] mfpu_be_i,
  output logic                   mfpu_gnt_o,
  output logic                   vrf_req_o,
  output logic [IdWidth-1:0]     vrf_id_o,
  output logic [AddrWidth-1:0]   vrf_addr_o,
  output logic [DataWidth-1:0]   vrf_wdata_o,
  output logic [DataWidth/8-1:0] vrf_be_o,
  input  logic                   vrf_gnt_i,
  output logic [15:0]            alu_wr_cnt_o,
  output logic [15:0]            mfpu_wr_cnt_o
);

  logic rr_q;
  logic free;
  logic both_req;

  always_comb begin
    free       = !vrf_req_o || vrf_gnt_i;
    both_req   = alu_req_i && mfpu_req_i;
    alu_gnt_o  = 1'b0;
    mfpu_gnt_o = 1'b0;
    // rr_q only matters when both sources compete; 0 favours the ALU.
    if (!rst_i && free) begin
      if (alu_req_i && (!mfpu_req_i || !rr_q)) begin
        alu_gnt_o = 1'b1;
      end else if (mfpu_req_i) begin
        mfpu_gnt_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vrf_req_o     <= 1'b0;
      vrf_id_o      <= '0;
      vrf_addr_o    <= '0;
      vrf_wdata_o   <= '0;
      vrf_be_o      <= '0;
      rr_q          <= 1'b0;
      alu_wr_cnt_o  <= '0;
      mfpu_wr_cnt_o <= '0;
    end else begin
      if (alu_gnt_o) begin
        vrf_req_o   <= 1'b1;
        vrf_id_o    <= alu_id_i;
        vrf_addr_o  <= alu_addr_i;
        vrf_wdata_o <= alu_wdata_i;
        vrf_be_o    <= alu_be_i;
      end else if (mfpu_gnt_o) begin
        vrf_req_o   <= 1'b1;
        vrf_id_o    <= mfpu_id_i;
        vrf_addr_o  <= mfpu_addr_i;
        vrf_wdata_o <= mfpu_wdata_i;
        vrf_be_o    <= mfpu_be_i;
      end else if (vrf_gnt_i) begin
        vrf_req_o <= 1'b0;
      end

      // Point at the loser of a contested grant so it wins next time.
      if (both_req && (alu_gnt_o || mfpu_gnt_o)) begin
        rr_q <= alu_gnt_o;
      end

      if (alu_gnt_o && (alu_wr_cnt_o != 16'hFFFF)) begin
        alu_wr_cnt_o <= alu_wr_cnt_o + 16'd1;
      end
      if (mfpu_gnt_o && (mfpu_wr_cnt_o != 16'hFFFF)) begin
        mfpu_wr_cnt_o <= mfpu_wr_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vfu_wb_arbiter.sv
// tb/tb_vfu_wb_arbiter.sv - Scoreboard bench for vfu_wb_arbiter with a transaction-level reference model.
module tb_vfu_wb_arbiter;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int IW = 3;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } wr_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          alu_req_i, mfpu_req_i, vrf_gnt_i;
  logic [IW-1:0] alu_id_i, mfpu_id_i, vrf_id_o;
  logic [AW-1:0] alu_addr_i, mfpu_addr_i, vrf_addr_o;
  logic [DW-1:0] alu_wdata_i, mfpu_wdata_i, vrf_wdata_o;
  logic [BW-1:0] alu_be_i, mfpu_be_i, vrf_be_o;
  logic          alu_gnt_o, mfpu_gnt_o, vrf_req_o;
  logic [15:0]   alu_wr_cnt_o, mfpu_wr_cnt_o;

  vfu_wb_arbiter #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_req_i(alu_req_i), .alu_id_i(alu_id_i), .alu_addr_i(alu_addr_i),
    .alu_wdata_i(alu_wdata_i), .alu_be_i(alu_be_i), .alu_gnt_o(alu_gnt_o),
    .mfpu_req_i(mfpu_req_i), .mfpu_id_i(mfpu_id_i), .mfpu_addr_i(mfpu_addr_i),
    .mfpu_wdata_i(mfpu_wdata_i), .mfpu_be_i(mfpu_be_i), .mfpu_gnt_o(mfpu_gnt_o),
    .vrf_req_o(vrf_req_o), .vrf_id_o(vrf_id_o), .vrf_addr_o(vrf_addr_o),
    .vrf_wdata_o(vrf_wdata_o), .vrf_be_o(vrf_be_o), .vrf_gnt_i(vrf_gnt_i),
    .alu_wr_cnt_o(alu_wr_cnt_o), .mfpu_wr_cnt_o(mfpu_wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  // Stimulus knobs (percent probabilities) and reset request.
  int  p_alu = 0, p_mfpu = 0, p_vgnt = 0;
  bit  rst_k = 1'b0;
  bit  fixed = 1'b0;

  // Reference model: slot occupancy, fairness pointer, accepted-write tallies.
  bit  m_full = 1'b0;
  bit  m_prefer_mfpu = 1'b0;
  int  m_alu_cnt = 0, m_mfpu_cnt = 0;
  int  alu_wait = 0, mfpu_wait = 0;
  bit  alu_done = 1'b0, mfpu_done = 1'b0;
  int  n_alu = 0, n_mfpu = 0;

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic wr_t rand_wr();
    wr_t w;
    w.id    = IW'($urandom);
    w.addr  = AW'($urandom);
    w.wdata = {$urandom, $urandom};
    w.be    = BW'($urandom);
    return w;
  endfunction

  task automatic step();
    wr_t w;
    int  winner;
    bit  free;
    @(negedge clk_i);
    rst_i = rst_k;
    if (alu_done) begin alu_req_i = 1'b0; alu_done = 1'b0; end
    if (mfpu_done) begin mfpu_req_i = 1'b0; mfpu_done = 1'b0; end
    if (!alu_req_i) begin
      w = rand_wr();
      if (fixed) begin w.addr = AW'('h12); w.wdata = 64'hDEAD; w.be = 8'hFF; end
      {alu_id_i, alu_addr_i, alu_wdata_i, alu_be_i} = w;
      alu_req_i = (int'($urandom_range(99)) < p_alu);
    end
    if (!mfpu_req_i) begin
      w = rand_wr();
      {mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i} = w;
      mfpu_req_i = (int'($urandom_range(99)) < p_mfpu);
    end
    vrf_gnt_i = (int'($urandom_range(99)) < p_vgnt);
    #2;
    chk("vrf_req", 96'(vrf_req_o), 96'(m_full));
    if (m_full) begin
      chk("slot_depth", 96'(exp_q.size()), 96'd1);
      if (exp_q.size() > 0)
        chk("payload_held", 96'({vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o}), 96'(exp_q[0]));
    end
    chk("alu_cnt", 96'(alu_wr_cnt_o), 96'(m_alu_cnt));
    chk("mfpu_cnt", 96'(mfpu_wr_cnt_o), 96'(m_mfpu_cnt));

    // 0 = none, 1 = ALU, 2 = MFPU
    free   = !m_full || vrf_gnt_i;
    winner = 0;
    if (!rst_i && free) begin
      if (alu_req_i && mfpu_req_i) winner = m_prefer_mfpu ? 2 : 1;
      else if (alu_req_i)          winner = 1;
      else if (mfpu_req_i)         winner = 2;
    end
    chk("alu_gnt", 96'(alu_gnt_o), 96'(winner == 1));
    chk("mfpu_gnt", 96'(mfpu_gnt_o), 96'(winner == 2));

    if (rst_i) begin
      m_full = 0; m_prefer_mfpu = 0; m_alu_cnt = 0; m_mfpu_cnt = 0;
      alu_wait = 0; mfpu_wait = 0;
      exp_q.delete();
    end else begin
      if (free && alu_req_i && winner != 1) alu_wait++;
      if (free && mfpu_req_i && winner != 2) mfpu_wait++;
      if (winner != 0) begin
        if (alu_req_i && mfpu_req_i) m_prefer_mfpu = (winner == 1);
        m_full = 1;
      end else if (vrf_gnt_i) begin
        m_full = 0;
      end
      if (winner == 1) begin
        exp_q.push_back(wr_t'({alu_id_i, alu_addr_i, alu_wdata_i, alu_be_i}));
        chk("alu_fair", 96'(alu_wait <= 2), 96'd1);
        alu_wait = 0; alu_done = 1; n_alu++;
        if (m_alu_cnt < 65535) m_alu_cnt++;
      end else if (winner == 2) begin
        exp_q.push_back(wr_t'({mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i}));
        chk("mfpu_fair", 96'(mfpu_wait <= 2), 96'd1);
        mfpu_wait = 0; mfpu_done = 1; n_mfpu++;
        if (m_mfpu_cnt < 65535) m_mfpu_cnt++;
      end
    end
  endtask

  // Monitor: every accepted VRF transfer must match the oldest outstanding grant.
  always begin
    wr_t got;
    @(negedge clk_i);
    #4;
    if (!rst_i && vrf_req_o === 1'b1 && vrf_gnt_i === 1'b1) begin
      got = wr_t'({vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o});
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 96'(got), 96'd0);
      end else begin
        chk("xfer_payload", 96'(got), 96'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_i = 1'b1; vrf_gnt_i = 1'b0;
    alu_req_i = 1'b0; mfpu_req_i = 1'b0;
    {alu_id_i, alu_addr_i, alu_wdata_i, alu_be_i} = '0;
    {mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i} = '0;
    repeat (2) @(posedge clk_i);

    // Reset holds everything low even with requests pending.
    rst_k = 1; p_alu = 100; p_mfpu = 100; p_vgnt = 100;
    repeat (2) step();
    chk("rst_addr", 96'(vrf_addr_o), 96'd0);
    chk("rst_wdata", 96'(vrf_wdata_o), 96'd0);
    rst_k = 0; p_alu = 0; p_mfpu = 0;
    alu_req_i = 0; mfpu_req_i = 0;
    repeat (2) step();

    // Single ALU write with a known payload.
    fixed = 1; p_alu = 100;
    step();
    fixed = 0; p_alu = 0;
    step();
    chk("single_addr", 96'(vrf_addr_o), 96'h12);
    chk("single_wdata", 96'(vrf_wdata_o), 96'hDEAD);
    step();
    chk("single_cnt", 96'(alu_wr_cnt_o), 96'd1);

    // Continuous contention: strict alternation, no bubbles.
    p_alu = 100; p_mfpu = 100; p_vgnt = 100;
    repeat (20) step();
    chk("alt_balance", 96'((n_alu - n_mfpu) <= 1 && (n_mfpu - n_alu) <= 1), 96'd1);

    // Bank stall then release.
    p_vgnt = 0;
    repeat (5) step();
    p_vgnt = 100;
    repeat (3) step();

    // Reset with an output pending; ALU must win first afterwards.
    p_vgnt = 0;
    step();
    rst_k = 1;
    step();
    rst_k = 0; p_vgnt = 100;
    repeat (3) step();

    // Random traffic.
    p_alu = 50; p_mfpu = 50; p_vgnt = 60;
    repeat (3000) step();

    // Counter saturation.
    p_alu = 100; p_mfpu = 0; p_vgnt = 100;
    repeat (65540) step();
    chk("alu_sat", 96'(alu_wr_cnt_o), 96'hFFFF);

    p_alu = 0; p_mfpu = 0;
    repeat (4) step();
    chk("drained", 96'(exp_q.size()), 96'(m_full));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
